genaxis_reg_rw_arb: RTL and testbench
=====================================

# genaxis_reg_rw_arb

Two-to-one arbiter between the write and read register-request channels of the AXI-Lite register front end. It shares a single-port register bank (one address bus, one enable) between the two channels. It grants one channel at a time and forwards address, data and strobes to the bank. It returns the bank's ack and read data to the granted channel, and holds the losing channel in wait so its upstream timeout does not fire.

## Interface
- DATA_WIDTH, 32, register data width in bits
- ADDR_WIDTH, 32, register address width in bits
- STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- s_wr_addr  in  ADDR_WIDTH  write-channel address
- s_wr_data  in  DATA_WIDTH  write-channel data
- s_wr_strb  in  STRB_WIDTH  write-channel byte strobes
- s_wr_en  in  1  write request, held until ack or upstream timeout
- s_wr_wait  out  1  write channel stalled (pending, or bank wait)
- s_wr_ack  out  1  write complete
- s_rd_addr  in  ADDR_WIDTH  read-channel address
- s_rd_en  in  1  read request, held until ack or upstream timeout
- s_rd_data  out  DATA_WIDTH  read data, valid with s_rd_ack
- s_rd_wait  out  1  read channel stalled
- s_rd_ack  out  1  read complete
- m_reg_addr  out  ADDR_WIDTH  bank address (registered)
- m_reg_wdata  out  DATA_WIDTH  bank write data (registered)
- m_reg_wstrb  out  STRB_WIDTH  bank strobes (registered; 0 on reads)
- m_reg_we  out  1  1 = write, 0 = read (registered)
- m_reg_en  out  1  bank access active (registered)
- m_reg_rdata  in  DATA_WIDTH  bank read data
- m_reg_wait  in  1  bank requests extension
- m_reg_ack  in  1  bank access complete

## Operation
- FSM states: IDLE, WR, RD, GAP. Reset state is IDLE.
- last_grant is a 1-bit flag: 0 = write, 1 = read. It resets to 1, so the first tie goes to write.
- IDLE:
  - If only s_wr_en is high, go to WR.
  - If only s_rd_en is high, go to RD.
  - If both are high, grant the side not equal to last_grant.
  - On any grant, latch addr/data/strb into the m_reg_* registers, set m_reg_en=1, and set m_reg_we accordingly. For reads, m_reg_wstrb=0 and m_reg_wdata=0.
- WR/RD:
  - The granted channel's ack is m_reg_ack gated by state. On ack: clear m_reg_en, update last_grant, go to GAP.
  - s_rd_data = m_reg_rdata, qualified only by s_rd_ack.
- Abort: if the granted channel's en drops before m_reg_ack (upstream timeout), clear m_reg_en and go to GAP. No ack is issued. A late m_reg_ack in GAP/IDLE is ignored.
- GAP: lasts one cycle with m_reg_en=0, then IDLE. During GAP, requests are ignored, so a requester's still-high en in the cycle after ack is not re-granted.
- Wait outputs:
  - Granted channel: s_x_wait = m_reg_wait.
  - Non-granted channel with en high: s_x_wait = 1, in every state including IDLE of a cycle where the other side wins.
  - Otherwise 0.
- Ack outputs: the non-granted channel never sees ack.

## Timing
- Reset values: m_reg_en=0, m_reg_we=0, m_reg_addr/wdata/wstrb=0, all s_* acks and waits 0, s_rd_data follows m_reg_rdata.
- Request latency: s_x_en high in IDLE at cycle N gives m_reg_en high at N+1.
- Ack is combinational: m_reg_ack at cycle M gives s_x_ack at M and m_reg_en low at M+1.
- Minimum back-to-back spacing: 3 cycles per access (grant, ack, GAP).
- m_reg_* outputs are stable while m_reg_en is high.
- Reset mid-access: all outputs are forced to reset values asynchronously and the FSM returns to IDLE. No ack is issued.

## Configuration
- GENAXIS_REG_ARB_WR_PRIO_EN defined: fixed priority, write always wins a tie, and last_grant is unused.
- Macro undefined: round-robin via last_grant, as described above.

## Structure
- Shared package/include genaxis_reg_pkg holds:
  - FSM state encodings (IDLE=2'd0, WR=2'd1, RD=2'd2, GAP=2'd3);
  - the grant encoding constants GRANT_WR=1'b0 and GRANT_RD=1'b1.
- One sub-module, genaxis_reg_arb_pick: the combinational two-way picker. Inputs: wr_req, rd_req, last_grant. Outputs: grant_valid, grant_rd. The priority macro is resolved inside it.

## Test plan
- Single write, addr 0x10, data 0xDEADBEEF, strb 0xF; bank acks 2 cycles after m_reg_en → m_reg_we=1 and m_reg_en high for exactly 3 cycles; s_wr_ack pulses once; m_reg_en low for the GAP cycle.
- Single read, addr 0x20; bank returns 0x12345678 with ack → s_rd_ack and s_rd_data=0x12345678 in the same cycle; m_reg_wstrb=0.
- Simultaneous wr/rd from reset, repeated 4× → without the macro, grants alternate W,R,W,R and the loser's wait is held high throughout. With GENAXIS_REG_ARB_WR_PRIO_EN, writes are always granted first.
- Bank holds m_reg_wait=1 for 10 cycles on a read → s_rd_wait=1 for those cycles, then the ack completes normally.
- Upstream drops s_wr_en after 4 cycles with no ack (timeout) → m_reg_en falls the next cycle with no s_wr_ack; a late m_reg_ack is ignored; a subsequent read completes correctly.
- rst asserted mid-write → all outputs are 0 immediately; after release, a new read is granted at N+1.

Source files
------------

// File: rtl/genaxis_reg_pkg.sv
// Shared types for the AXI-Lite register front end: arbiter FSM states and grant encoding.
package genaxis_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

    localparam logic GRANT_WR = 1'b0;
    localparam logic GRANT_RD = 1'b1;

endpackage

// File: rtl/genaxis_reg_rw_arb_if.sv
// Bundle of the write/read request channels and the single-port register bank bus.
// master = arbiter side, slave = requesters plus bank.
interface genaxis_reg_rw_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] s_wr_addr;
    logic [DATA_WIDTH-1:0] s_wr_data;
    logic [STRB_WIDTH-1:0] s_wr_strb;
    logic                  s_wr_en;
    logic                  s_wr_wait;
    logic                  s_wr_ack;

    logic [ADDR_WIDTH-1:0] s_rd_addr;
    logic                  s_rd_en;
    logic [DATA_WIDTH-1:0] s_rd_data;
    logic                  s_rd_wait;
    logic                  s_rd_ack;

    logic [ADDR_WIDTH-1:0] m_reg_addr;
    logic [DATA_WIDTH-1:0] m_reg_wdata;
    logic [STRB_WIDTH-1:0] m_reg_wstrb;
    logic                  m_reg_we;
    logic                  m_reg_en;
    logic [DATA_WIDTH-1:0] m_reg_rdata;
    logic                  m_reg_wait;
    logic                  m_reg_ack;

    modport master (
        input  s_wr_addr, s_wr_data, s_wr_strb, s_wr_en,
        output s_wr_wait, s_wr_ack,
        input  s_rd_addr, s_rd_en,
        output s_rd_data, s_rd_wait, s_rd_ack,
        output m_reg_addr, m_reg_wdata, m_reg_wstrb, m_reg_we, m_reg_en,
        input  m_reg_rdata, m_reg_wait, m_reg_ack
    );

    modport slave (
        output s_wr_addr, s_wr_data, s_wr_strb, s_wr_en,
        input  s_wr_wait, s_wr_ack,
        output s_rd_addr, s_rd_en,
        input  s_rd_data, s_rd_wait, s_rd_ack,
        input  m_reg_addr, m_reg_wdata, m_reg_wstrb, m_reg_we, m_reg_en,
        output m_reg_rdata, m_reg_wait, m_reg_ack
    );

endinterface

// File: rtl/genaxis_reg_arb_pick.sv
// Combinational two-way picker between write and read requests.
// GENAXIS_REG_ARB_WR_PRIO_EN selects fixed write priority; otherwise round-robin on last_grant.
module genaxis_reg_arb_pick
    import genaxis_reg_pkg::*;
(
    input  logic wr_req,
    input  logic rd_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_rd
);

    // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latch).
    always_comb begin
        grant_valid = wr_req | rd_req;
        grant_rd    = 1'b0;
`ifdef GENAXIS_REG_ARB_WR_PRIO_EN
        grant_rd    = rd_req & ~wr_req;
`else
        if (wr_req && rd_req) begin
            grant_rd = (last_grant == GRANT_WR);
        end else begin
            grant_rd = rd_req;
        end
`endif
    end

`ifdef GENAXIS_REG_ARB_WR_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/genaxis_reg_rw_arb.sv
// Write/read arbiter sharing one single-port register bank; grants one channel at a time.
// Optional GENAXIS_REG_ARB_WR_PRIO_EN (resolved in genaxis_reg_arb_pick) gives writes fixed priority.
module genaxis_reg_rw_arb
    import genaxis_reg_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                 clk,
    input  logic                 rst,
    genaxis_reg_rw_arb_if.master bus
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       grant_valid, grant_rd;
    logic       load, release_bank;
    logic       wr_ack, rd_ack, wr_wait, rd_wait;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  we_q;
    logic                  en_q;

    genaxis_reg_arb_pick u_pick (
        .wr_req      (bus.s_wr_en),
        .rd_req      (bus.s_rd_en),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_rd    (grant_rd)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_RD;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        release_bank = 1'b0;
        wr_ack       = 1'b0;
        rd_ack       = 1'b0;
        wr_wait      = 1'b0;
        rd_wait      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The side that loses this cycle's pick is told to wait immediately.
                wr_wait = bus.s_wr_en & grant_rd;
                rd_wait = bus.s_rd_en & ~grant_rd;
                if (grant_valid) begin
                    load    = 1'b1;
                    state_d = grant_rd ? RD : WR;
                end
            end
            WR: begin
                wr_ack  = bus.m_reg_ack;
                wr_wait = bus.m_reg_wait;
                rd_wait = bus.s_rd_en;
                if (bus.m_reg_ack) begin
                    release_bank = 1'b1;
                    last_grant_d = GRANT_WR;
                    state_d      = GAP;
                end else if (!bus.s_wr_en) begin
                    release_bank = 1'b1;
                    state_d      = GAP;
                end
            end
            RD: begin
                rd_ack  = bus.m_reg_ack;
                rd_wait = bus.m_reg_wait;
                wr_wait = bus.s_wr_en;
                if (bus.m_reg_ack) begin
                    release_bank = 1'b1;
                    last_grant_d = GRANT_RD;
                    state_d      = GAP;
                end else if (!bus.s_rd_en) begin
                    release_bank = 1'b1;
                    state_d      = GAP;
                end
            end
            GAP: begin
                // Requests still high right after an ack are deliberately not re-granted here.
                wr_wait = bus.s_wr_en;
                rd_wait = bus.s_rd_en;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
            en_q    <= 1'b0;
        end else if (load) begin
            addr_q  <= grant_rd ? bus.s_rd_addr : bus.s_wr_addr;
            wdata_q <= grant_rd ? '0 : bus.s_wr_data;
            wstrb_q <= grant_rd ? '0 : bus.s_wr_strb;
            we_q    <= ~grant_rd;
            en_q    <= 1'b1;
        end else if (release_bank) begin
            en_q    <= 1'b0;
        end
    end

    assign bus.m_reg_addr  = addr_q;
    assign bus.m_reg_wdata = wdata_q;
    assign bus.m_reg_wstrb = wstrb_q;
    assign bus.m_reg_we    = we_q;
    assign bus.m_reg_en    = en_q;

    // Waits are combinational from requests, so they are masked while reset is held.
    assign bus.s_wr_ack  = wr_ack;
    assign bus.s_rd_ack  = rd_ack;
    assign bus.s_wr_wait = wr_wait & ~rst;
    assign bus.s_rd_wait = rd_wait & ~rst;
    assign bus.s_rd_data = bus.m_reg_rdata;

`ifndef SYNTHESIS
    ap_bank_stable: assert property (@(posedge clk) disable iff (rst)
        (en_q && $past(en_q)) |-> $stable({addr_q, wdata_q, wstrb_q, we_q}));
    ap_single_ack: assert property (@(posedge clk) disable iff (rst)
        !(wr_ack && rd_ack));
`endif

endmodule

// File: tb/tb_genaxis_reg_rw_arb.sv
// Self-checking bench for genaxis_reg_rw_arb: per-cycle owner/gap model plus directed literal checks.
module tb_genaxis_reg_rw_arb;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;
`ifdef GENAXIS_REG_ARB_WR_PRIO_EN
    localparam bit WR_PRIO = 1'b1;
`else
    localparam bit WR_PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    genaxis_reg_rw_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    genaxis_reg_rw_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bank responder: ack bank_lat cycles after the first wait-free cycle, wait for bank_wait_n cycles.
    bit          bank_auto;
    int          bank_lat;
    int          bank_wait_n;
    int          bank_cnt;
    logic        auto_ack, auto_wait, late_ack;
    logic [DW-1:0] bank_rdata;

    assign bus.m_reg_ack   = auto_ack | late_ack;
    assign bus.m_reg_wait  = auto_wait;
    assign bus.m_reg_rdata = bank_rdata;

    initial begin
        bank_cnt  = 0;
        auto_ack  = 1'b0;
        auto_wait = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !bus.m_reg_en || !bank_auto) bank_cnt = 0;
            else bank_cnt = bank_cnt + 1;
            auto_wait = (bank_cnt != 0) && (bank_cnt <= bank_wait_n);
            auto_ack  = (bank_cnt != 0) && (bank_cnt == bank_wait_n + bank_lat + 1);
        end
    end

    // Model: who owns the bank (0 none, 1 write, 2 read), whether this is the gap cycle, and the bank request.
    int            m_owner;
    bit            m_gap;
    bit            m_last_rd;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_we, m_en;

    function automatic int pick_side(input logic w, input logic r, input bit last_rd);
        if (w && r) return (WR_PRIO || last_rd) ? 1 : 2;
        if (w) return 1;
        if (r) return 2;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= 0; m_gap <= 1'b0; m_last_rd <= 1'b1;
            m_addr <= '0; m_wdata <= '0; m_wstrb <= '0; m_we <= 1'b0; m_en <= 1'b0;
        end else if (m_gap) begin
            m_gap <= 1'b0;
        end else if (m_owner != 0) begin
            if (bus.m_reg_ack) begin
                m_last_rd <= (m_owner == 2);
                m_owner <= 0; m_gap <= 1'b1; m_en <= 1'b0;
            end else if (!((m_owner == 1) ? bus.s_wr_en : bus.s_rd_en)) begin
                m_owner <= 0; m_gap <= 1'b1; m_en <= 1'b0;
            end
        end else begin
            case (pick_side(bus.s_wr_en, bus.s_rd_en, m_last_rd))
                1: begin
                    m_owner <= 1; m_addr <= bus.s_wr_addr; m_wdata <= bus.s_wr_data;
                    m_wstrb <= bus.s_wr_strb; m_we <= 1'b1; m_en <= 1'b1;
                end
                2: begin
                    m_owner <= 2; m_addr <= bus.s_rd_addr; m_wdata <= '0;
                    m_wstrb <= '0; m_we <= 1'b0; m_en <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    function automatic logic exp_wait(input int side, input logic en_x);
        if (rst) return 1'b0;
        if (m_owner == side) return bus.m_reg_wait;
        if (!en_x) return 1'b0;
        if (m_owner != 0 || m_gap) return 1'b1;
        return pick_side(bus.s_wr_en, bus.s_rd_en, m_last_rd) != side;
    endfunction

    // Per-cycle comparison and event counters, sampled on the falling edge.
    int en_cycles, wr_ack_cnt, rd_ack_cnt, rd_wait_cycles;

    initial begin
        forever begin
            @(negedge clk);
            check("m_reg_en",    bus.m_reg_en,    m_en);
            check("m_reg_we",    bus.m_reg_we,    m_we);
            check("m_reg_addr",  bus.m_reg_addr,  m_addr);
            check("m_reg_wdata", bus.m_reg_wdata, m_wdata);
            check("m_reg_wstrb", bus.m_reg_wstrb, m_wstrb);
            check("s_wr_ack",    bus.s_wr_ack,    !rst && m_owner == 1 && bus.m_reg_ack);
            check("s_rd_ack",    bus.s_rd_ack,    !rst && m_owner == 2 && bus.m_reg_ack);
            check("s_wr_wait",   bus.s_wr_wait,   exp_wait(1, bus.s_wr_en));
            check("s_rd_wait",   bus.s_rd_wait,   exp_wait(2, bus.s_rd_en));
            check("s_rd_data",   bus.s_rd_data,   bank_rdata);
            if (bus.m_reg_en)  en_cycles++;
            if (bus.s_wr_ack)  wr_ack_cnt++;
            if (bus.s_rd_ack)  rd_ack_cnt++;
            if (bus.s_rd_wait) rd_wait_cycles++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        en_cycles = 0; wr_ack_cnt = 0; rd_ack_cnt = 0; rd_wait_cycles = 0;
    endtask

    task automatic wait_rd_ack(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.s_rd_ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit        seen;
        bit        wa, ra;
        int        seq[$];

        rst = 1'b1;
        bus.s_wr_addr = '0; bus.s_wr_data = '0; bus.s_wr_strb = '0; bus.s_wr_en = 1'b0;
        bus.s_rd_addr = '0; bus.s_rd_en = 1'b0;
        bank_auto = 1'b1; bank_lat = 2; bank_wait_n = 0; late_ack = 1'b0;
        bank_rdata = 32'hA5A5_0000;
        repeat (3) tick();
        @(negedge clk);
        check("reset_en",   bus.m_reg_en,   1'b0);
        check("reset_we",   bus.m_reg_we,   1'b0);
        check("reset_addr", bus.m_reg_addr, 32'h0);
        check("reset_wait", {bus.s_wr_wait, bus.s_rd_wait}, 2'b00);
        tick();
        rst = 1'b0;

        // Single write, bank acks two cycles after m_reg_en rises.
        tick();
        clear_counts();
        bus.s_wr_addr = 32'h10; bus.s_wr_data = 32'hDEAD_BEEF; bus.s_wr_strb = 4'hF; bus.s_wr_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) check("wr_latency_en_low", bus.m_reg_en, 1'b0);
            if (i == 1) begin
                check("wr_grant_en",    bus.m_reg_en,    1'b1);
                check("wr_grant_we",    bus.m_reg_we,    1'b1);
                check("wr_grant_addr",  bus.m_reg_addr,  32'h10);
                check("wr_grant_wdata", bus.m_reg_wdata, 32'hDEAD_BEEF);
                check("wr_grant_wstrb", bus.m_reg_wstrb, 4'hF);
            end
            if (bus.s_wr_ack) begin
                seen = 1'b1;
                check("wr_ack_cycle", i, 3);
                break;
            end
        end
        check("wr_ack_seen", seen, 1'b1);
        tick();
        bus.s_wr_en = 1'b0;
        @(negedge clk);
        check("wr_gap_en_low", bus.m_reg_en, 1'b0);
        repeat (3) tick();
        check("wr_en_cycles", en_cycles, 3);
        check("wr_ack_pulses", wr_ack_cnt, 1);

        // Single read, data returned with the ack.
        bank_rdata = 32'h1234_5678;
        clear_counts();
        bus.s_rd_addr = 32'h20; bus.s_rd_en = 1'b1;
        wait_rd_ack(20, seen);
        check("rd_ack_seen", seen, 1'b1);
        check("rd_data",  bus.s_rd_data,   32'h1234_5678);
        check("rd_wstrb", bus.m_reg_wstrb, 4'h0);
        check("rd_we",    bus.m_reg_we,    1'b0);
        check("rd_addr",  bus.m_reg_addr,  32'h20);
        tick();
        bus.s_rd_en = 1'b0;
        repeat (3) tick();
        check("rd_ack_pulses", rd_ack_cnt, 1);

        // Simultaneous requests from reset: each side drops only for the gap cycle after its ack.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        bus.s_wr_addr = 32'h30; bus.s_wr_data = 32'h0000_0030; bus.s_wr_strb = 4'h5;
        bus.s_rd_addr = 32'h34;
        bus.s_wr_en = 1'b1; bus.s_rd_en = 1'b1;
        for (int cyc = 0; cyc < 80 && seq.size() < 4; cyc++) begin
            @(negedge clk);
            wa = bus.s_wr_ack;
            ra = bus.s_rd_ack;
            if (wa) seq.push_back(0);
            if (ra) seq.push_back(1);
            tick();
            bus.s_wr_en = !wa;
            bus.s_rd_en = !ra;
        end
        check("tie_grant_count", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) begin
            check($sformatf("tie_grant_%0d", i), seq[i], WR_PRIO ? 0 : (i % 2));
        end
        bus.s_wr_en = 1'b0; bus.s_rd_en = 1'b0;
        repeat (3) tick();

        // Bank stretches a read with 10 wait cycles.
        bank_wait_n = 10;
        bank_rdata = 32'h0BAD_CAFE;
        clear_counts();
        bus.s_rd_addr = 32'h24; bus.s_rd_en = 1'b1;
        wait_rd_ack(40, seen);
        check("rdwait_ack_seen", seen, 1'b1);
        check("rdwait_data", bus.s_rd_data, 32'h0BAD_CAFE);
        check("rdwait_cycles", rd_wait_cycles, 10);
        tick();
        bus.s_rd_en = 1'b0;
        bank_wait_n = 0;
        repeat (3) tick();

        // Upstream timeout on a write, then a late bank ack, then a clean read.
        bank_auto = 1'b0;
        clear_counts();
        bus.s_wr_addr = 32'h50; bus.s_wr_data = 32'h1111_2222; bus.s_wr_strb = 4'h3; bus.s_wr_en = 1'b1;
        repeat (4) tick();
        bus.s_wr_en = 1'b0;
        @(negedge clk);
        check("abort_en_before", bus.m_reg_en, 1'b1);
        tick();
        late_ack = 1'b1;
        @(negedge clk);
        check("abort_en_low", bus.m_reg_en, 1'b0);
        check("abort_late_ack_gap", bus.s_wr_ack, 1'b0);
        tick();
        @(negedge clk);
        check("abort_late_ack_idle", {bus.s_wr_ack, bus.s_rd_ack}, 2'b00);
        tick();
        late_ack = 1'b0;
        bank_auto = 1'b1;
        bank_rdata = 32'hCAFE_F00D;
        bus.s_rd_addr = 32'h60; bus.s_rd_en = 1'b1;
        wait_rd_ack(20, seen);
        check("post_abort_rd_seen", seen, 1'b1);
        check("post_abort_rd_data", bus.s_rd_data, 32'hCAFE_F00D);
        check("post_abort_rd_addr", bus.m_reg_addr, 32'h60);
        tick();
        bus.s_rd_en = 1'b0;
        repeat (2) tick();
        check("abort_no_wr_ack", wr_ack_cnt, 0);

        // Reset in the middle of a write with a read waiting.
        bank_auto = 1'b0;
        bus.s_wr_addr = 32'h70; bus.s_wr_data = 32'h7777_7777; bus.s_wr_strb = 4'hC; bus.s_wr_en = 1'b1;
        bus.s_rd_addr = 32'h74; bus.s_rd_en = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("midrst_pre_en",     bus.m_reg_en,  1'b1);
        check("midrst_pre_we",     bus.m_reg_we,  1'b1);
        check("midrst_pre_rdwait", bus.s_rd_wait, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_en",    bus.m_reg_en,    1'b0);
        check("midrst_we",    bus.m_reg_we,    1'b0);
        check("midrst_addr",  bus.m_reg_addr,  32'h0);
        check("midrst_wdata", bus.m_reg_wdata, 32'h0);
        check("midrst_wstrb", bus.m_reg_wstrb, 4'h0);
        check("midrst_waits", {bus.s_wr_wait, bus.s_rd_wait}, 2'b00);
        check("midrst_acks",  {bus.s_wr_ack, bus.s_rd_ack}, 2'b00);
        bus.s_wr_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_en_low", bus.m_reg_en, 1'b0);
        @(negedge clk);
        check("post_rst_rd_en",   bus.m_reg_en,   1'b1);
        check("post_rst_rd_we",   bus.m_reg_we,   1'b0);
        check("post_rst_rd_addr", bus.m_reg_addr, 32'h74);
        bank_auto = 1'b1;
        wait_rd_ack(20, seen);
        check("post_rst_rd_seen", seen, 1'b1);
        tick();
        bus.s_rd_en = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
